// File: rtl/spi_xact_ctrl.sv
// Transaction sequencer for the SPI memory datapath: bit-counted address/data
// phases with one-cycle Moore strobes for address latch, load, write and MISO.
module spi_xact_ctrl #(
  parameter int FRAME_BITS = 8,
  parameter int CNT_W      = 4,
  parameter int MEM_LAT    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs_n,
  input  logic             sclk_pos,
  input  logic             sr_pout0,
  output logic             addr_we,
  output logic             sr_load,
  output logic             dm_we,
  output logic             miso_en,
  output logic             rw,
  output logic             busy,
  output logic             proto_err,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    ADDR        = 4'd1,
    ADDR_SETTLE = 4'd2,
    LATCH       = 4'd3,
    RD_WAIT     = 4'd4,
    RD_LOAD     = 4'd5,
    RD_SHIFT    = 4'd6,
    WR_SHIFT    = 4'd7,
    WR_SETTLE   = 4'd8,
    WR_COMMIT   = 4'd9,
    DONE        = 4'd10
  } state_t;

  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [1:0]       LAT_LAST  = 2'(MEM_LAT - 1);

  state_t     state;
  state_t     next_state;
  logic [1:0] lat_cnt;
  logic       abort;
  logic       stray_pulse;

  // Abort and stray-pulse qualifiers shared by next-state and datapath logic
  always_comb begin
    abort       = (state != IDLE) && cs_n;
    stray_pulse = 1'b0;
    if (!abort && sclk_pos) begin
      case (state)
        ADDR_SETTLE, LATCH, RD_WAIT, RD_LOAD, WR_SETTLE, WR_COMMIT: stray_pulse = 1'b1;
        default:                                                     stray_pulse = 1'b0;
      endcase
    end else begin
      stray_pulse = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; chip-select release overrides every other transition
  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:        next_state = cs_n ? IDLE : ADDR;
        ADDR:        next_state = (sclk_pos && (bit_cnt == FRAME_CNT - CNT_ONE)) ? ADDR_SETTLE : ADDR;
        ADDR_SETTLE: next_state = LATCH;
        LATCH:       next_state = sr_pout0 ? RD_WAIT : WR_SHIFT;
        RD_WAIT:     next_state = (lat_cnt == LAT_LAST) ? RD_LOAD : RD_WAIT;
        RD_LOAD:     next_state = RD_SHIFT;
        RD_SHIFT:    next_state = (bit_cnt == FRAME_CNT) ? DONE : RD_SHIFT;
        WR_SHIFT:    next_state = (bit_cnt == FRAME_CNT) ? WR_SETTLE : WR_SHIFT;
        WR_SETTLE:   next_state = WR_COMMIT;
        WR_COMMIT:   next_state = DONE;
        DONE:        next_state = DONE;
        default:     next_state = IDLE;
      endcase
    end
  end

  // Bit/latency counters, R/W flag and sticky protocol error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      lat_cnt   <= 2'd0;
      rw        <= 1'b0;
      proto_err <= 1'b0;
    end else if (abort) begin
      bit_cnt <= '0;
      lat_cnt <= 2'd0;
    end else begin
      if (stray_pulse) begin
        proto_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          lat_cnt <= 2'd0;
          if (!cs_n) begin
            proto_err <= 1'b0;
          end
        end
        ADDR: begin
          if (sclk_pos) begin
            bit_cnt <= (bit_cnt == FRAME_CNT - CNT_ONE) ? '0 : bit_cnt + CNT_ONE;
          end
        end
        LATCH: begin
          rw      <= sr_pout0;
          lat_cnt <= 2'd0;
        end
        RD_WAIT: lat_cnt <= lat_cnt + 2'd1;
        // Data phase counts saturate so overrun pulses are simply dropped
        RD_SHIFT, WR_SHIFT: begin
          if (sclk_pos && (bit_cnt != FRAME_CNT)) begin
            bit_cnt <= bit_cnt + CNT_ONE;
          end
        end
        default: begin
          bit_cnt <= bit_cnt;
        end
      endcase
    end
  end

  // Moore output decode from the state register
  always_comb begin
    addr_we = 1'b0;
    sr_load = 1'b0;
    dm_we   = 1'b0;
    miso_en = 1'b0;
    busy    = (state != IDLE);
    case (state)
      LATCH:     addr_we = 1'b1;
      RD_LOAD:   sr_load = 1'b1;
      WR_COMMIT: dm_we   = 1'b1;
      RD_SHIFT:  miso_en = 1'b1;
      DONE:      miso_en = rw;
      default:   miso_en = 1'b0;
    endcase
  end

endmodule

// File: doc/spi_xact_ctrl.md
# spi_xact_ctrl

Transaction sequencer for the SPI memory datapath: shift register, address latch, data memory, MISO output flip-flop and tristate buffer. It consumes the conditioned chip-select and SCLK edge pulses from the input conditioners. It then issues one-cycle strobes that latch the address, load the shift register from memory, commit writes, and enable MISO. It replaces the ad-hoc datapath FSM with an explicit bit-counted, abort-safe protocol engine.

## Interface
Parameters:
- FRAME_BITS, 8, bits per frame (7 address + 1 R/W flag; also data byte length)
- CNT_W, 4, bit counter width, must satisfy 2**CNT_W > FRAME_BITS
- MEM_LAT, 1, cycles between addr_we and valid memory dataOut (1..3)

Ports:
- clk  in  1  FPGA clock; all state changes on posedge
- rst_n  in  1  asynchronous, active-low reset
- cs_n  in  1  conditioned chip select, active low
- sclk_pos  in  1  one-cycle pulse on SCLK rising edge
- sr_pout0  in  1  shift register parallelDataOut[0] (R/W flag; 1 = read)
- addr_we  out  1  address latch enable
- sr_load  out  1  shift register parallel load
- dm_we  out  1  data memory write enable
- miso_en  out  1  tristate buffer enable
- rw  out  1  registered R/W flag for current transaction
- busy  out  1  high in every state except IDLE
- proto_err  out  1  sticky protocol error, cleared on next transaction start
- bit_cnt  out  CNT_W  current in-frame bit count

## Operation
- States: IDLE, ADDR, ADDR_SETTLE, LATCH, RD_WAIT, RD_LOAD, RD_SHIFT, WR_SHIFT, WR_SETTLE, WR_COMMIT, DONE.
- Outputs are Moore-decoded from the state register: addr_we only in LATCH, sr_load only in RD_LOAD, dm_we only in WR_COMMIT, miso_en only in RD_SHIFT and DONE-after-read (rw=1). busy = (state != IDLE).
- IDLE: cs_n=0 -> ADDR; bit_cnt<=0; proto_err<=0.
- ADDR: each sclk_pos increments bit_cnt; on the pulse that makes bit_cnt = FRAME_BITS -> ADDR_SETTLE, bit_cnt<=0.
- ADDR_SETTLE: 1 cycle (shift register parallelDataOut lags one clk) -> LATCH.
- LATCH: 1 cycle; rw<=sr_pout0; sr_pout0=1 -> RD_WAIT, else -> WR_SHIFT.
- RD_WAIT: MEM_LAT cycles -> RD_LOAD (1 cycle) -> RD_SHIFT.
- RD_SHIFT: count sclk_pos; at FRAME_BITS -> DONE.
- WR_SHIFT: count sclk_pos; at FRAME_BITS -> WR_SETTLE (1 cycle) -> WR_COMMIT (1 cycle) -> DONE.
- DONE: further sclk_pos ignored; no new strobes; cs_n=1 -> IDLE.
- Abort: cs_n=1 in any non-IDLE state -> IDLE at the next edge, and takes priority over every other transition. A write aborted before WR_COMMIT never asserts dm_we. bit_cnt<=0. rw and proto_err hold their values.
- proto_err set if sclk_pos is seen in ADDR_SETTLE, LATCH, RD_WAIT, RD_LOAD, WR_SETTLE or WR_COMMIT. The pulse is not counted, and the sequence continues.
- bit_cnt saturates at FRAME_BITS and never wraps.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, every output 0, bit_cnt=0. Release is synchronous to the next clk edge.
- Reset mid-transaction: same as reset; no strobe is emitted during or after it.
- The 8th address sclk_pos is sampled at edge k: ADDR_SETTLE during cycle k, LATCH (addr_we=1) during k+1.
- Read: RD_LOAD (sr_load=1) at cycle k+2+MEM_LAT; miso_en rises the same cycle RD_SHIFT is entered, at k+3+MEM_LAT.
- Write: the 8th data sclk_pos is sampled at edge j; dm_we=1 during cycle j+2 only.
- Every strobe is exactly one cycle wide. At most one of addr_we/sr_load/dm_we is high in any cycle.
- Simultaneous cs_n=1 and sclk_pos: abort wins; the pulse is neither counted nor flagged.

## Test plan
- Write 0xA5 to address 0x2A: frame 0x54 then 0xA5, cs_n high after. Required: addr_we once, rw=0, dm_we exactly once 2 cycles after the 16th sclk_pos, miso_en never high, proto_err=0.
- Read address 0x2A: frame 0x55 with MEM_LAT=1. Required: rw=1, sr_load exactly 3 cycles after the 8th sclk_pos, miso_en high from the next cycle until cs_n rises, dm_we never high.
- Write aborted: cs_n=1 after 5 data pulses. Required: state IDLE next edge, dm_we never asserted, busy=0, bit_cnt=0.
- Overrun: 12 sclk_pos during a read data phase. Required: DONE after 8, pulses 9-12 ignored, no extra strobes, proto_err=0.
- Protocol error: sclk_pos injected during LATCH. Required: proto_err=1 until the next cs_n fall, and bit_cnt unchanged.
- Async reset asserted in WR_SHIFT at bit 6, then released. Required: all outputs 0 immediately (no clk edge), state IDLE; the next full write completes normally.
